// File: rtl/mux2to1_rr_arbiter.sv
// mux2to1_rr_arbiter
//   Upstream select/feed stage for the 2:1 mux datapath. Two valid/ready input
//   streams are arbitrated round-robin, optionally holding a grant for a
//   fixed-length burst. The winning beat is registered together with the select
//   value that chose it, so downstream sees a consistent {s, y} pair.
//   One-deep output buffer, one-cycle latency.
//
// Parameters
//   WIDTH  data width of i0_data, i1_data, y
//   BURST  beats granted to one input before priority rotates (1..255)
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   synchronous active-high reset
//   i0_valid  in   input 0 beat available
//   i0_data   in   input 0 beat
//   i0_ready  out  input 0 beat accepted this cycle (combinational)
//   i1_valid  in   input 1 beat available
//   i1_data   in   input 1 beat
//   i1_ready  out  input 1 beat accepted this cycle (combinational)
//   y_valid   out  output register holds a beat
//   y_ready   in   downstream accepts y this cycle
//   y         out  registered output beat
//   s         out  source of the beat in y: 0 = i0, 1 = i1

module mux2to1_rr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BURST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  output logic             i1_ready,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [WIDTH-1:0] y,
  output logic             s
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] BURST_LAST = CW'(BURST);
  localparam bit SINGLE = (BURST == 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          pri, pri_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          load;
  logic          gnt_valid;
  logic          gnt;
  logic          xfer;

  // Output register can take a new beat when empty or being drained.
  assign load = !y_valid || y_ready;

  // Grant selection; a locked burst only ever considers its owner.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = 1'b0;
    case (state)
      IDLE: begin
        if (i0_valid && i1_valid) begin
          gnt_valid = 1'b1;
          gnt       = pri;
        end else if (i0_valid) begin
          gnt_valid = 1'b1;
          gnt       = 1'b0;
        end else if (i1_valid) begin
          gnt_valid = 1'b1;
          gnt       = 1'b1;
        end
      end
      LOCK0: begin
        gnt_valid = i0_valid;
        gnt       = 1'b0;
      end
      LOCK1: begin
        gnt_valid = i1_valid;
        gnt       = 1'b1;
      end
      default: begin
        gnt_valid = 1'b0;
        gnt       = 1'b0;
      end
    endcase
  end

  assign i0_ready = !rst && load && gnt_valid && !gnt;
  assign i1_ready = !rst && load && gnt_valid && gnt;
  assign xfer     = i0_ready || i1_ready;
  assign cnt_inc  = cnt + CW'(1);

  // Burst FSM: nothing moves while the output is stalled.
  always_comb begin
    state_nxt = state;
    pri_nxt   = pri;
    cnt_nxt   = cnt;
    if (load) begin
      case (state)
        IDLE: begin
          if (xfer) begin
            if (SINGLE) begin
              pri_nxt = ~gnt;
            end else begin
              state_nxt = gnt ? LOCK1 : LOCK0;
              cnt_nxt   = CW'(1);
            end
          end
        end
        LOCK0, LOCK1: begin
          // Without a transfer the owner went idle: release early.
          if (xfer && (cnt_inc != BURST_LAST)) begin
            cnt_nxt = cnt_inc;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            pri_nxt   = (state == LOCK0);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pri   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pri   <= pri_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Output buffer; y and s keep their value when drained without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      y       <= '0;
      s       <= 1'b0;
      y_valid <= 1'b0;
    end else if (xfer) begin
      y       <= i1_ready ? i1_data : i0_data;
      s       <= i1_ready;
      y_valid <= 1'b1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
module tb_mux2to1_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       i0_valid, i1_valid, y_ready;
  logic [7:0] i0_data, i1_data;

  // Index 0: BURST=1 instance, index 1: BURST=3 instance.
  logic [1:0] rdy0, rdy1, yv, so;
  logic [7:0] yo [2];

  int n_cmp = 0;
  int n_bad = 0;

  mux2to1_rr_arbiter #(.WIDTH(8), .BURST(1)) u1 (
    .clk(clk), .rst(rst),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(rdy0[0]),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(rdy1[0]),
    .y_valid(yv[0]), .y_ready(y_ready), .y(yo[0]), .s(so[0])
  );

  mux2to1_rr_arbiter #(.WIDTH(8), .BURST(3)) u3 (
    .clk(clk), .rst(rst),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(rdy0[1]),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(rdy1[1]),
    .y_valid(yv[1]), .y_ready(y_ready), .y(yo[1]), .s(so[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [7:0] da,
                       input logic b, input logic [7:0] db, input logic yr);
    @(posedge clk);
    #1;
    rst = r; i0_valid = a; i0_data = da; i1_valid = b; i1_data = db; y_ready = yr;
  endtask

  task automatic chk_out(input int k, input string tag, input logic r0, input logic r1,
                         input logic v, input logic [7:0] d, input logic sel);
    chk({tag, ".i0_ready"}, 32'(rdy0[k]), 32'(r0));
    chk({tag, ".i1_ready"}, 32'(rdy1[k]), 32'(r1));
    chk({tag, ".y_valid"},  32'(yv[k]),   32'(v));
    chk({tag, ".y"},        32'(yo[k]),   32'(d));
    chk({tag, ".s"},        32'(so[k]),   32'(sel));
  endtask

  // Reference model: a burst budget owned by one input, plus whose turn it is.
  int         m_owner [2];
  int         m_taken [2];
  int         m_turn  [2];
  logic       m_yv    [2];
  logic [7:0] m_y     [2];
  logic       m_s     [2];
  int         m_burst [2] = '{1, 3};

  function automatic logic in_valid(input int g);
    return (g == 0) ? i0_valid : i1_valid;
  endfunction

  function automatic int m_grant(input int k);
    if (rst) return -1;
    if (m_yv[k] && !y_ready) return -1;
    if (m_owner[k] >= 0) return in_valid(m_owner[k]) ? m_owner[k] : -1;
    if (i0_valid && i1_valid) return m_turn[k];
    if (i0_valid) return 0;
    if (i1_valid) return 1;
    return -1;
  endfunction

  task automatic m_step(input int k);
    int g;
    g = m_grant(k);
    if (rst) begin
      m_owner[k] = -1; m_taken[k] = 0; m_turn[k] = 0;
      m_yv[k] = 1'b0; m_y[k] = 8'h00; m_s[k] = 1'b0;
    end else if (g >= 0) begin
      m_y[k]  = (g == 0) ? i0_data : i1_data;
      m_s[k]  = (g == 1);
      m_yv[k] = 1'b1;
      m_taken[k] = ((m_owner[k] < 0) ? 0 : m_taken[k]) + 1;
      if (m_taken[k] >= m_burst[k]) begin
        m_owner[k] = -1; m_taken[k] = 0; m_turn[k] = 1 - g;
      end else begin
        m_owner[k] = g;
      end
    end else if (!m_yv[k] || y_ready) begin
      m_yv[k] = 1'b0;
      if (m_owner[k] >= 0) begin
        m_turn[k] = 1 - m_owner[k]; m_owner[k] = -1; m_taken[k] = 0;
      end
    end
  endtask

  typedef struct {
    logic       rst;
    logic       i0v;
    logic [7:0] d0;
    logic       i1v;
    logic [7:0] d1;
    logic       yr;
    logic       full;
    logic       r0;
    logic       r1;
    logic       yv;
    logic [7:0] y;
    logic       s;
  } vec_t;

  vec_t tbl [14];

  logic       exp_s [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] bd;

  initial begin
    rst = 1'b1; i0_valid = 1'b0; i1_valid = 1'b0; y_ready = 1'b0;
    i0_data = 8'h00; i1_data = 8'h00;

    // Expected values are the state seen in that cycle (BURST=1 instance).
    //          rst   i0v   d0     i1v   d1     yr    full  r0    r1    yv    y      s
    tbl[0]  = '{1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 8'h20, 1'b1, 8'h30, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'h21, 1'b1, 8'h31, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h22, 1'b1, 8'h32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h31, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 8'h23, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h40, 1'b1, 8'h50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 8'h40, 1'b1, 8'h50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 8'h40, 1'b1, 8'h50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 8'h40, 1'b1, 8'h50, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h40, 1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rst, tbl[i].i0v, tbl[i].d0, tbl[i].i1v, tbl[i].d1, tbl[i].yr);
      @(negedge clk);
      if (tbl[i].full) begin
        chk_out(0, $sformatf("tbl%0d", i), tbl[i].r0, tbl[i].r1, tbl[i].yv, tbl[i].y, tbl[i].s);
      end else begin
        chk($sformatf("tbl%0d.i0_ready", i), 32'(rdy0[0]), 32'(tbl[i].r0));
        chk($sformatf("tbl%0d.i1_ready", i), 32'(rdy1[0]), 32'(tbl[i].r1));
      end
    end

    // BURST=3 rotation 0,0,0,1,1,1,0 then early release of the LOCK0 burst.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 7; k++) begin
      drive(1'b0, 1'b1, 8'(8'h60 + k), 1'b1, 8'(8'h70 + k), 1'b1);
      @(negedge clk);
      if (k > 0) begin
        bd = exp_s[k-1] ? 8'(8'h70 + k - 1) : 8'(8'h60 + k - 1);
        chk($sformatf("b3_beat%0d.s", k - 1), 32'(so[1]), 32'(exp_s[k-1]));
        chk($sformatf("b3_beat%0d.y", k - 1), 32'(yo[1]), 32'(bd));
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h7A, 1'b1);
    @(negedge clk);
    chk_out(1, "b3_release", 1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h7A, 1'b1);
    @(negedge clk);
    chk_out(1, "b3_bubble", 1'b0, 1'b1, 1'b0, 8'h66, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk_out(1, "b3_after", 1'b0, 1'b0, 1'b1, 8'h7A, 1'b1);

    // Reset while LOCK1 holds cnt=2; the first grant afterwards is i0.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 8'(8'h80 + k), 1'b1, 8'(8'h90 + k), 1'b1);
    end
    drive(1'b1, 1'b1, 8'hC0, 1'b1, 8'hD0, 1'b1);
    @(negedge clk);
    chk_out(1, "mid_rst_in", 1'b0, 1'b0, 1'b1, 8'h94, 1'b1);
    drive(1'b0, 1'b1, 8'hC1, 1'b1, 8'hD1, 1'b1);
    @(negedge clk);
    chk_out(1, "mid_rst_out", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    chk_out(1, "mid_rst_first", 1'b0, 1'b0, 1'b1, 8'hC1, 1'b0);

    // Random traffic on both instances against the reference model.
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    m_step(0);
    m_step(1);
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 8'($urandom),
            ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) != 0));
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk_out(k, $sformatf("rnd%0d_b%0d", c, m_burst[k]),
                (m_grant(k) == 0), (m_grant(k) == 1), m_yv[k], m_y[k], m_s[k]);
        m_step(k);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
